// File: rtl/pwm_ramp_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pwm_ramp_ctrl_pkg : register map, FSM encodings, ramp step helper        |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package pwm_ramp_ctrl_pkg;

  localparam logic [1:0] ADDR_PRESCALE = 2'd0;
  localparam logic [1:0] ADDR_TARGET   = 2'd1;
  localparam logic [1:0] ADDR_STEP     = 2'd2;
  localparam logic [1:0] ADDR_CTRL     = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RAMP = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_STOP = 2'd3;

  localparam int CTRL_MOD_BIT   = 0;
  localparam int CTRL_DWELL_LSB = 4;
  localparam int CTRL_DWELL_MSB = 7;

  // One ramp step toward tgt; 9-bit math so the result never wraps past 0/255.
  function automatic logic [7:0] step_toward(input logic [7:0] cur,
                                             input logic [7:0] tgt,
                                             input logic [7:0] step);
    logic [8:0] s;
    logic [8:0] diff;
    logic [8:0] nxt;
    s = (step == 8'd0) ? 9'd1 : {1'b0, step};
    if (tgt >= cur) begin
      diff = {1'b0, tgt} - {1'b0, cur};
      nxt  = {1'b0, cur} + s;
    end else begin
      diff = {1'b0, cur} - {1'b0, tgt};
      nxt  = {1'b0, cur} - s;
    end
    step_toward = (diff <= s) ? tgt : nxt[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_ramp_ctrl_prescaler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pwm_prescaler : divides clk into the run_ctrl clock-enable (period P+1)  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module pwm_prescaler
  import pwm_ramp_ctrl_pkg::*;
#(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc,
  output logic               run_ctrl
);

  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic               run_ctrl_q, run_ctrl_d;

  // presc only changes together with clr, so pcnt never overshoots it.
  always_comb begin
    pcnt_d     = (clr || (pcnt_q == presc)) ? '0 : pcnt_q + 1'b1;
    run_ctrl_d = !clr && (pcnt_q == presc);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt_q     <= '0;
      run_ctrl_q <= 1'b0;
    end else begin
      pcnt_q     <= pcnt_d;
      run_ctrl_q <= run_ctrl_d;
    end
  end

  assign run_ctrl = run_ctrl_q;

endmodule
`default_nettype wire

// File: rtl/pwm_ramp_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pwm_ramp_ctrl : register-driven width ramp controller for the PWM/FM gen |
// | Option PWM_RAMP_SOFTSTOP_EN: stop ramps width to 0 before disabling.     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module pwm_ramp_ctrl
  import pwm_ramp_ctrl_pkg::*;
#(
  parameter logic [7:0] WIDTH_INIT = 8'h33,
  parameter int         PRESC_W    = 8,
  parameter int         DWELL_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_wr,
  input  logic [1:0] cfg_addr,
  input  logic [7:0] cfg_wdata,
  input  logic       start,
  input  logic       stop,
  output logic       run_ctrl,
  output logic       pwm_oen,
  output logic       pwm_mod,
  output logic [7:0] pwm_width,
  output logic       busy,
  output logic       done
);

`ifdef PWM_RAMP_SOFTSTOP_EN
  localparam logic [1:0] STOP_NEXT = ST_STOP;
`else
  localparam logic [1:0] STOP_NEXT = ST_IDLE;
`endif

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [7:0]         target_q, target_d;
  logic [7:0]         step_q, step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               mod_cfg_q, mod_cfg_d;
  logic [1:0]         state_q, state_d;
  logic [7:0]         width_q, width_d;
  logic [DWELL_W-1:0] dcnt_q, dcnt_d;
  logic               pwm_mod_q, pwm_mod_d;
  logic               pwm_oen_q, pwm_oen_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               presc_clr;
  logic               ramping;
  logic               step_now;
  logic [7:0]         ramp_tgt;
  logic [7:0]         next_w;

  assign presc_clr = cfg_wr && (cfg_addr == ADDR_PRESCALE);

  pwm_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk      (clk),
    .rst      (rst),
    .clr      (presc_clr),
    .presc    (presc_q),
    .run_ctrl (run_ctrl)
  );

  always_comb begin
    presc_d   = presc_q;
    target_d  = target_q;
    step_d    = step_q;
    dwell_d   = dwell_q;
    mod_cfg_d = mod_cfg_q;
    if (cfg_wr) begin
      case (cfg_addr)
        ADDR_PRESCALE: presc_d  = PRESC_W'(cfg_wdata);
        ADDR_TARGET:   target_d = cfg_wdata;
        ADDR_STEP:     step_d   = cfg_wdata;
        default: begin
          dwell_d   = DWELL_W'(cfg_wdata[CTRL_DWELL_MSB:CTRL_DWELL_LSB]);
          mod_cfg_d = cfg_wdata[CTRL_MOD_BIT];
        end
      endcase
    end
  end

  // >= rather than == keeps stepping alive if dwell is lowered mid-ramp.
  assign ramping  = (state_q == ST_RAMP) || (state_q == ST_STOP);
  assign step_now = run_ctrl && (dcnt_q >= dwell_q);
  assign ramp_tgt = (state_q == ST_STOP) ? 8'h00 : target_q;
  assign next_w   = step_toward(width_q, ramp_tgt, step_q);

  always_comb begin
    state_d   = state_q;
    width_d   = width_q;
    dcnt_d    = dcnt_q;
    pwm_mod_d = pwm_mod_q;
    done_d    = 1'b0;

    if (ramping && !stop && run_ctrl) begin
      if (step_now) begin
        dcnt_d  = '0;
        width_d = next_w;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        dcnt_d = '0;
        if (start && !stop) begin
          state_d   = ST_RAMP;
          pwm_mod_d = mod_cfg_d;
        end
      end
      ST_RAMP: begin
        if (stop) begin
          state_d = STOP_NEXT;
          dcnt_d  = '0;
        end else if (step_now && (next_w == target_q)) begin
          state_d = ST_HOLD;
          done_d  = 1'b1;
        end
      end
      ST_HOLD: begin
        dcnt_d = '0;
        // Comparing the register also catches a TARGET write that raced the final step.
        if (stop) state_d = STOP_NEXT;
        else if (target_q != width_q) state_d = ST_RAMP;
      end
`ifdef PWM_RAMP_SOFTSTOP_EN
      ST_STOP: begin
        if (stop) state_d = ST_IDLE;
        else if (step_now && (next_w == 8'h00)) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    pwm_oen_d = (state_d == ST_IDLE);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q   <= '0;
      target_q  <= WIDTH_INIT;
      step_q    <= 8'd1;
      dwell_q   <= '0;
      mod_cfg_q <= 1'b1;
      state_q   <= ST_IDLE;
      width_q   <= WIDTH_INIT;
      dcnt_q    <= '0;
      pwm_mod_q <= 1'b1;
      pwm_oen_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      target_q  <= target_d;
      step_q    <= step_d;
      dwell_q   <= dwell_d;
      mod_cfg_q <= mod_cfg_d;
      state_q   <= state_d;
      width_q   <= width_d;
      dcnt_q    <= dcnt_d;
      pwm_mod_q <= pwm_mod_d;
      pwm_oen_q <= pwm_oen_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign pwm_oen   = pwm_oen_q;
  assign pwm_mod   = pwm_mod_q;
  assign pwm_width = width_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
`default_nettype wire
